// File: rtl/sim_mem_pkg.sv
// Shared types and constants for the simulation memory bridge:
// FSM encoding, MMIO decode constants, LFSR seed/taps and a debug view.
package sim_mem_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WAIT   = 2'd1,
        ACCESS = 2'd2,
        RESP   = 2'd3
    } state_t;

    localparam logic [31:0] CON_ADDR_DEF   = 32'h1000_0000;
    localparam logic [31:0] PASS_ADDR_DEF  = 32'h2000_0000;
    localparam logic [31:0] PASS_VALUE_DEF = 32'd123456789;

    localparam logic [15:0] LFSR_SEED = 16'hACE1;
    // Taps 16,14,13,11 of a right-shifting Fibonacci LFSR land on bits 0,2,3,5.
    localparam logic [15:0] LFSR_TAPS = 16'h002D;

    typedef struct packed {
        state_t      state;
        logic [8:0]  cnt;
        logic [15:0] lfsr;
    } dbg_t;

    function automatic logic [15:0] lfsr_next(input logic [15:0] s);
        return {^(s & LFSR_TAPS), s[15:1]};
    endfunction

endpackage

// File: rtl/sim_mem_bridge_lfsr.sv
// 16-bit Fibonacci LFSR that steps only when enabled; used to draw
// pseudo-random extra wait states, one draw per accepted request.
module sim_lfsr16
    import sim_mem_pkg::*;
#(
    parameter logic [15:0] SEED = LFSR_SEED
) (
    input  logic        clock,
    input  logic        resetn,
    input  logic        en,
    output logic [15:0] value
);

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            value <= SEED;
        end else if (en) begin
            value <= lfsr_next(value);
        end
    end

endmodule

// File: rtl/sim_mem_bridge.sv
// Bridge from the PicoRV32 native memory port to a 1-cycle synchronous SRAM,
// with wait-state injection, console/pass MMIO words and sticky error flags.
module sim_mem_bridge
    import sim_mem_pkg::*;
#(
    parameter int          MEM_WORDS   = 32768,
    parameter int          WAIT_CYCLES = 0,
    parameter int          RAND_STALL  = 0,
    parameter logic [31:0] CON_ADDR    = CON_ADDR_DEF,
    parameter logic [31:0] PASS_ADDR   = PASS_ADDR_DEF,
    parameter logic [31:0] PASS_VALUE  = PASS_VALUE_DEF,
    localparam int         AW          = $clog2(MEM_WORDS)
) (
    input  logic          clock,
    input  logic          resetn,
    // Handshake: the core holds mem_valid and the request fields stable until
    // the single-cycle mem_ready pulse; the request is consumed on that edge.
    input  logic          mem_valid,
    input  logic [31:0]   mem_addr,
    input  logic [31:0]   mem_wdata,
    input  logic [3:0]    mem_wstrb,
    output logic          mem_ready,
    output logic [31:0]   mem_rdata,
    output logic          sram_en,
    output logic [3:0]    sram_we,
    output logic [AW-1:0] sram_addr,
    output logic [31:0]   sram_wdata,
    input  logic [31:0]   sram_rdata,
    output logic          con_valid,
    output logic [7:0]    con_data,
    output logic          tests_passed,
    output logic          bus_error,
    output dbg_t          dbg
);

    state_t      state, state_next;
    logic [8:0]  cnt_q, cnt_next, start_cnt;
    logic [31:0] addr_q, wdata_q;
    logic [3:0]  wstrb_q;
    logic [15:0] lfsr;
    logic        accept;
    logic        ram_hit, is_con, is_pass, pass_ok, proto_bad;

    sim_lfsr16 #(.SEED(LFSR_SEED)) u_lfsr (
        .clock  (clock),
        .resetn (resetn),
        .en     (accept),
        .value  (lfsr)
    );

    assign start_cnt = 9'(WAIT_CYCLES) + ((RAND_STALL != 0) ? {7'd0, lfsr[1:0]} : 9'd0);
    assign ram_hit   = (addr_q[31:AW+2] == '0);
    assign is_con    = (addr_q == CON_ADDR);
    assign is_pass   = (addr_q == PASS_ADDR);
    assign pass_ok   = is_pass && (wstrb_q == 4'hF) && (wdata_q == PASS_VALUE);
    // Any drift of the held request while it is in flight is a core bug.
    assign proto_bad = (state != IDLE) &&
                       (!mem_valid || mem_addr != addr_q ||
                        mem_wdata != wdata_q || mem_wstrb != wstrb_q);

    assign sram_addr  = addr_q[AW+1:2];
    assign sram_wdata = wdata_q;
    assign dbg        = {state, cnt_q, lfsr};

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state        <= IDLE;
            cnt_q        <= '0;
            addr_q       <= '0;
            wdata_q      <= '0;
            wstrb_q      <= '0;
            tests_passed <= 1'b0;
            bus_error    <= 1'b0;
        end else begin
            state <= state_next;
            cnt_q <= cnt_next;
            if (accept) begin
                addr_q  <= mem_addr;
                wdata_q <= mem_wdata;
                wstrb_q <= mem_wstrb;
            end
            if (state == ACCESS && pass_ok) begin
                tests_passed <= 1'b1;
            end
            if ((state == ACCESS && !(ram_hit || is_con || is_pass)) || proto_bad) begin
                bus_error <= 1'b1;
            end
        end
    end

    always_comb begin
        state_next = state;
        cnt_next   = cnt_q;
        accept     = 1'b0;
        mem_ready  = 1'b0;
        mem_rdata  = '0;
        sram_en    = 1'b0;
        sram_we    = '0;
        con_valid  = 1'b0;
        con_data   = '0;
        case (state)
            IDLE: begin
                if (mem_valid) begin
                    accept     = 1'b1;
                    cnt_next   = start_cnt;
                    state_next = (start_cnt != 0) ? WAIT : ACCESS;
                end
            end
            WAIT: begin
                cnt_next = cnt_q - 9'd1;
                if (cnt_q == 9'd1) begin
                    state_next = ACCESS;
                end
            end
            ACCESS: begin
                if (ram_hit) begin
                    sram_en = 1'b1;
                    sram_we = wstrb_q;
                end else if (is_con && wstrb_q != 4'h0) begin
                    con_valid = 1'b1;
                    con_data  = wdata_q[7:0];
                end
                state_next = RESP;
            end
            RESP: begin
                mem_ready = 1'b1;
                // SRAM data issued in ACCESS arrives exactly in this cycle.
                if (ram_hit && wstrb_q == 4'h0) begin
                    mem_rdata = sram_rdata;
                end
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

endmodule

// File: tb/tb_sim_mem_bridge.sv
// Directed bench for sim_mem_bridge: three instances (0 waits, 3 waits,
// 3 waits + random stall), each with its own behavioural SRAM.
module tb_sim_mem_bridge;
    import sim_mem_pkg::*;

    logic        clock, resetn;
    logic        mem_valid [3];
    logic [31:0] mem_addr [3], mem_wdata [3];
    logic [3:0]  mem_wstrb [3];
    logic        mem_ready [3];
    logic [31:0] mem_rdata [3];
    logic        sram_en [3];
    logic [3:0]  sram_we [3];
    logic [7:0]  sram_addr [3];
    logic [31:0] sram_wdata [3], sram_rdata [3];
    logic        con_valid [3];
    logic [7:0]  con_data [3];
    logic        tests_passed [3], bus_error [3];
    dbg_t        dbg [3];

    logic [31:0] ram [3][256];
    int          ready_cnt [3];
    int          con_cnt [3];
    logic [7:0]  con_last [3];
    int          total = 0;
    int          bad = 0;

    localparam logic [31:0] CON  = 32'h1000_0000;
    localparam logic [31:0] PASS = 32'h2000_0000;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        sim_mem_bridge #(
            .MEM_WORDS   (256),
            .WAIT_CYCLES (g == 0 ? 0 : 3),
            .RAND_STALL  (g == 2 ? 1 : 0)
        ) u_dut (
            .clock        (clock),
            .resetn       (resetn),
            .mem_valid    (mem_valid[g]),
            .mem_addr     (mem_addr[g]),
            .mem_wdata    (mem_wdata[g]),
            .mem_wstrb    (mem_wstrb[g]),
            .mem_ready    (mem_ready[g]),
            .mem_rdata    (mem_rdata[g]),
            .sram_en      (sram_en[g]),
            .sram_we      (sram_we[g]),
            .sram_addr    (sram_addr[g]),
            .sram_wdata   (sram_wdata[g]),
            .sram_rdata   (sram_rdata[g]),
            .con_valid    (con_valid[g]),
            .con_data     (con_data[g]),
            .tests_passed (tests_passed[g]),
            .bus_error    (bus_error[g]),
            .dbg          (dbg[g])
        );
    end

    initial clock = 1'b0;
    always #5 clock = ~clock;

    always @(posedge clock) begin
        for (int d = 0; d < 3; d++) begin
            if (sram_en[d]) begin
                for (int b = 0; b < 4; b++) begin
                    if (sram_we[d][b]) ram[d][sram_addr[d]][b*8 +: 8] <= sram_wdata[d][b*8 +: 8];
                end
                sram_rdata[d] <= ram[d][sram_addr[d]];
            end
        end
    end

    always @(negedge clock) begin
        for (int d = 0; d < 3; d++) begin
            if (mem_ready[d]) ready_cnt[d] <= ready_cnt[d] + 1;
            if (con_valid[d]) begin
                con_cnt[d]  <= con_cnt[d] + 1;
                con_last[d] <= con_data[d];
            end
        end
    end

    task automatic do_reset();
        resetn = 1'b0;
        repeat (3) @(posedge clock);
        @(negedge clock);
        resetn = 1'b1;
    endtask

    // lat = cycles from valid to ready (0 if ready never came).
    task automatic req(input int d, input logic [31:0] a, input logic [31:0] wd,
                       input logic [3:0] ws, output logic [31:0] rd, output int lat);
        @(negedge clock);
        mem_valid[d] = 1'b1;
        mem_addr[d]  = a;
        mem_wdata[d] = wd;
        mem_wstrb[d] = ws;
        lat = 0;
        rd  = '0;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clock);
            if (mem_ready[d]) begin
                lat = i;
                rd  = mem_rdata[d];
                break;
            end
        end
        @(posedge clock);
        #1;
        mem_valid[d] = 1'b0;
        mem_wstrb[d] = 4'h0;
    endtask

    task automatic test_reset();
        for (int d = 0; d < 3; d++) begin
            total += 12;
            if (mem_ready[d] !== 1'b0) begin bad++; $display("FAIL rst_ready[%0d] got %b exp 0", d, mem_ready[d]); end
            if (mem_rdata[d] !== 32'h0) begin bad++; $display("FAIL rst_rdata[%0d] got %h exp 0", d, mem_rdata[d]); end
            if (sram_en[d] !== 1'b0) begin bad++; $display("FAIL rst_sram_en[%0d] got %b exp 0", d, sram_en[d]); end
            if (sram_we[d] !== 4'h0) begin bad++; $display("FAIL rst_sram_we[%0d] got %h exp 0", d, sram_we[d]); end
            if (sram_addr[d] !== 8'h0) begin bad++; $display("FAIL rst_sram_addr[%0d] got %h exp 0", d, sram_addr[d]); end
            if (sram_wdata[d] !== 32'h0) begin bad++; $display("FAIL rst_sram_wdata[%0d] got %h exp 0", d, sram_wdata[d]); end
            if (con_valid[d] !== 1'b0) begin bad++; $display("FAIL rst_con_valid[%0d] got %b exp 0", d, con_valid[d]); end
            if (con_data[d] !== 8'h0) begin bad++; $display("FAIL rst_con_data[%0d] got %h exp 0", d, con_data[d]); end
            if (tests_passed[d] !== 1'b0) begin bad++; $display("FAIL rst_passed[%0d] got %b exp 0", d, tests_passed[d]); end
            if (bus_error[d] !== 1'b0) begin bad++; $display("FAIL rst_bus_error[%0d] got %b exp 0", d, bus_error[d]); end
            if (dbg[d].state !== IDLE) begin bad++; $display("FAIL rst_state[%0d] got %0d exp 0", d, dbg[d].state); end
            if (dbg[d].lfsr !== 16'hACE1) begin bad++; $display("FAIL rst_lfsr[%0d] got %h exp ace1", d, dbg[d].lfsr); end
        end
    endtask

    task automatic test_write_read();
        logic [31:0] rd;
        int lat;
        req(0, 32'h100, 32'hDEADBEEF, 4'hF, rd, lat);
        total += 2;
        if (lat != 2) begin bad++; $display("FAIL wr_latency got %0d exp 2", lat); end
        if (rd !== 32'h0) begin bad++; $display("FAIL wr_rdata got %h exp 0", rd); end
        req(0, 32'h100, 32'h0, 4'h0, rd, lat);
        total += 2;
        if (lat != 2) begin bad++; $display("FAIL rd_latency got %0d exp 2", lat); end
        if (rd !== 32'hDEADBEEF) begin bad++; $display("FAIL rd_data got %h exp deadbeef", rd); end
    endtask

    task automatic test_partial();
        logic [31:0] rd;
        int lat;
        req(0, 32'h100, 32'h0000AB00, 4'b0010, rd, lat);
        req(0, 32'h100, 32'h0, 4'h0, rd, lat);
        total += 1;
        if (rd !== 32'hDEADABEF) begin bad++; $display("FAIL partial_data got %h exp deadabef", rd); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] rd;
        int lat;
        int rc;
        rc = ready_cnt[0];
        for (int i = 0; i < 3; i++) begin
            req(0, 32'h10 + 32'(i * 4), 32'(i + 1) * 32'h1111_1111, 4'hF, rd, lat);
            total += 1;
            if (lat != 2) begin bad++; $display("FAIL b2b_wr_lat[%0d] got %0d exp 2", i, lat); end
        end
        for (int i = 0; i < 3; i++) begin
            req(0, 32'h10 + 32'(i * 4), 32'h0, 4'h0, rd, lat);
            total += 1;
            if (rd !== 32'(i + 1) * 32'h1111_1111) begin bad++; $display("FAIL b2b_rd[%0d] got %h exp %h", i, rd, 32'(i + 1) * 32'h1111_1111); end
        end
        @(negedge clock);
        total += 1;
        if (ready_cnt[0] != rc + 6) begin bad++; $display("FAIL b2b_ready_pulses got %0d exp %0d", ready_cnt[0] - rc, 6); end
    endtask

    task automatic test_wait3();
        logic [31:0] rd;
        int lat;
        req(1, 32'h200, 32'h12345678, 4'hF, rd, lat);
        total += 1;
        if (lat != 5) begin bad++; $display("FAIL w3_wr_lat got %0d exp 5", lat); end
        req(1, 32'h200, 32'h0, 4'h0, rd, lat);
        total += 2;
        if (lat != 5) begin bad++; $display("FAIL w3_rd_lat got %0d exp 5", lat); end
        if (rd !== 32'h12345678) begin bad++; $display("FAIL w3_rd_data got %h exp 12345678", rd); end
    endtask

    task automatic test_rand_stall();
        int exp_lat [6] = '{6, 5, 5, 5, 7, 8};
        logic [31:0] rd;
        int lat;
        for (int run = 0; run < 2; run++) begin
            for (int i = 0; i < 6; i++) begin
                req(2, 32'h0, 32'h0, 4'h0, rd, lat);
                total += 1;
                if (lat != exp_lat[i]) begin bad++; $display("FAIL rand_lat run%0d[%0d] got %0d exp %0d", run, i, lat, exp_lat[i]); end
            end
            if (run == 0) do_reset();
        end
    endtask

    task automatic test_mmio();
        logic [31:0] rd;
        int lat;
        int cc;
        cc = con_cnt[0];
        req(0, CON, 32'h41, 4'hF, rd, lat);
        total += 3;
        if (con_cnt[0] != cc + 1) begin bad++; $display("FAIL con_pulses got %0d exp 1", con_cnt[0] - cc); end
        if (con_last[0] !== 8'h41) begin bad++; $display("FAIL con_data got %h exp 41", con_last[0]); end
        if (rd !== 32'h0) begin bad++; $display("FAIL con_rdata got %h exp 0", rd); end
        req(0, PASS, 32'd5, 4'hF, rd, lat);
        total += 1;
        if (tests_passed[0] !== 1'b0) begin bad++; $display("FAIL pass_wrong_value got %b exp 0", tests_passed[0]); end
        req(0, PASS, 32'd123456789, 4'b0111, rd, lat);
        total += 1;
        if (tests_passed[0] !== 1'b0) begin bad++; $display("FAIL pass_partial got %b exp 0", tests_passed[0]); end
        req(0, PASS, 32'd123456789, 4'hF, rd, lat);
        total += 1;
        if (tests_passed[0] !== 1'b1) begin bad++; $display("FAIL pass_set got %b exp 1", tests_passed[0]); end
        req(0, PASS, 32'h0, 4'h0, rd, lat);
        req(0, CON, 32'h0, 4'h0, rd, lat);
        total += 5;
        if (rd !== 32'h0) begin bad++; $display("FAIL mmio_read_data got %h exp 0", rd); end
        if (lat != 2) begin bad++; $display("FAIL mmio_read_lat got %0d exp 2", lat); end
        if (tests_passed[0] !== 1'b1) begin bad++; $display("FAIL pass_sticky got %b exp 1", tests_passed[0]); end
        if (con_cnt[0] != cc + 1) begin bad++; $display("FAIL con_read_side_effect got %0d exp 1", con_cnt[0] - cc); end
        if (bus_error[0] !== 1'b0) begin bad++; $display("FAIL mmio_bus_error got %b exp 0", bus_error[0]); end
    endtask

    task automatic test_bus_error();
        logic [31:0] rd;
        int lat;
        req(0, 32'h3FC, 32'hCAFEF00D, 4'hF, rd, lat);
        req(0, 32'h3FC, 32'h0, 4'h0, rd, lat);
        total += 2;
        if (rd !== 32'hCAFEF00D) begin bad++; $display("FAIL top_word_data got %h exp cafef00d", rd); end
        if (bus_error[0] !== 1'b0) begin bad++; $display("FAIL top_word_err got %b exp 0", bus_error[0]); end
        req(0, 32'h400, 32'h0, 4'h0, rd, lat);
        total += 3;
        if (lat != 2) begin bad++; $display("FAIL oor_lat got %0d exp 2", lat); end
        if (rd !== 32'h0) begin bad++; $display("FAIL oor_rdata got %h exp 0", rd); end
        if (bus_error[0] !== 1'b1) begin bad++; $display("FAIL oor_err got %b exp 1", bus_error[0]); end
        total += 1;
        if (bus_error[2] !== 1'b0) begin bad++; $display("FAIL far_err_before got %b exp 0", bus_error[2]); end
        req(2, 32'h4000_0000, 32'h0, 4'h0, rd, lat);
        total += 3;
        if (lat != 8) begin bad++; $display("FAIL far_lat got %0d exp 8", lat); end
        if (rd !== 32'h0) begin bad++; $display("FAIL far_rdata got %h exp 0", rd); end
        if (bus_error[2] !== 1'b1) begin bad++; $display("FAIL far_err got %b exp 1", bus_error[2]); end
    endtask

    task automatic test_protocol();
        bit got;
        total += 1;
        if (bus_error[1] !== 1'b0) begin bad++; $display("FAIL proto_err_before got %b exp 0", bus_error[1]); end
        @(negedge clock);
        mem_valid[1] = 1'b1;
        mem_addr[1]  = 32'h200;
        mem_wstrb[1] = 4'h0;
        repeat (2) @(negedge clock);
        mem_valid[1] = 1'b0;
        got = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clock);
            if (mem_ready[1]) begin got = 1'b1; break; end
        end
        total += 2;
        if (got !== 1'b1) begin bad++; $display("FAIL proto_ready got %b exp 1", got); end
        if (bus_error[1] !== 1'b1) begin bad++; $display("FAIL proto_err got %b exp 1", bus_error[1]); end
    endtask

    task automatic test_reset_mid();
        logic [31:0] rd;
        int lat;
        int rc;
        @(negedge clock);
        mem_valid[1] = 1'b1;
        mem_addr[1]  = 32'h200;
        mem_wstrb[1] = 4'h0;
        repeat (2) @(negedge clock);
        total += 1;
        if (dbg[1].state !== WAIT) begin bad++; $display("FAIL mid_state_before got %0d exp 1", dbg[1].state); end
        rc = ready_cnt[1];
        resetn = 1'b0;
        #1;
        total += 5;
        if (dbg[1].state !== IDLE) begin bad++; $display("FAIL mid_state got %0d exp 0", dbg[1].state); end
        if (mem_ready[1] !== 1'b0) begin bad++; $display("FAIL mid_ready got %b exp 0", mem_ready[1]); end
        if (sram_en[1] !== 1'b0) begin bad++; $display("FAIL mid_sram_en got %b exp 0", sram_en[1]); end
        if (bus_error[1] !== 1'b0) begin bad++; $display("FAIL mid_err got %b exp 0", bus_error[1]); end
        if (dbg[1].cnt !== 9'd0) begin bad++; $display("FAIL mid_cnt got %0d exp 0", dbg[1].cnt); end
        mem_valid[1] = 1'b0;
        repeat (6) @(negedge clock);
        total += 1;
        if (ready_cnt[1] != rc) begin bad++; $display("FAIL mid_no_ready got %0d exp 0", ready_cnt[1] - rc); end
        resetn = 1'b1;
        req(1, 32'h200, 32'h0, 4'h0, rd, lat);
        total += 2;
        if (lat != 5) begin bad++; $display("FAIL post_rst_lat got %0d exp 5", lat); end
        if (rd !== 32'h12345678) begin bad++; $display("FAIL post_rst_data got %h exp 12345678", rd); end
    endtask

    initial begin
        resetn = 1'b0;
        for (int d = 0; d < 3; d++) begin
            mem_valid[d] = 1'b0;
            mem_addr[d]  = '0;
            mem_wdata[d] = '0;
            mem_wstrb[d] = '0;
        end
        repeat (2) @(posedge clock);
        @(negedge clock);
        test_reset();
        resetn = 1'b1;
        test_write_read();
        test_partial();
        test_back_to_back();
        test_wait3();
        test_rand_stall();
        test_mmio();
        test_bus_error();
        test_protocol();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
